clk_ratio_detector: RTL

- Measures the division ratio and duty of a slow clock-like signal by sampling it in the reference clock domain.
- Reports period, high time and low time in reference cycles, and asserts lock after LOCK_COUNT consecutive identical periods.
- Used by the synchronization/receiver integration for two purposes: to check that divided-clock outputs match the programmed ratio, and to detect loss of the slow clock.

---
 rtl/clk_ratio_detector.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/clk_ratio_detector.sv
// -----------------------------------------------------------------------------
// clk_ratio_detector
//
// Measures a slow clock-like signal (i_div_clk) in the i_ref_clk domain. The
// block reports its period, high time and low time in reference cycles. It
// asserts lock after LOCK_COUNT consecutive identical periods, and it pulses a
// timeout when no rising edge arrives within 2^CNT_W-1 cycles.
//
// Parameters
//   CNT_W        width of the period/high/low counters (max period 2^CNT_W-2)
//   SYNC_STAGES  synchronizer depth on i_div_clk (>= 2)
//   LOCK_COUNT   consecutive equal periods needed for lock (>= 2)
//
// Ports
//   i_ref_clk   in   reference clock, all logic on its rising edge
//   i_rst       in   synchronous active-high reset
//   i_en        in   measurement enable; low holds the block idle
//   i_div_clk   in   asynchronous signal under measurement
//   o_ratio     out  last measured period in reference cycles
//   o_high_cnt  out  high cycles in the last period
//   o_low_cnt   out  low cycles in the last period (o_ratio - o_high_cnt)
//   o_valid     out  one-cycle pulse when the three fields update
//   o_locked    out  high while the period is stable
//   o_timeout   out  one-cycle pulse on loss of the measured clock
// -----------------------------------------------------------------------------
module clk_ratio_detector #(
  parameter int CNT_W       = 6,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 4
) (
  input  logic             i_ref_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_div_clk,
  output logic [CNT_W-1:0] o_ratio,
  output logic [CNT_W-1:0] o_high_cnt,
  output logic [CNT_W-1:0] o_low_cnt,
  output logic             o_valid,
  output logic             o_locked,
  output logic             o_timeout
);

  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);

  localparam logic [CNT_W-1:0]   CNT_MAX = '1;
  // The timeout fires on the cycle in which per_cnt would step onto CNT_MAX.
  // A rise seen while per_cnt holds this value is still a legal period of
  // 2^CNT_W-2 cycles, and the rise takes priority over the timeout.
  localparam logic [CNT_W-1:0]   CNT_TMO = CNT_MAX - CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);
  localparam logic [MATCH_W-1:0] LOCK_M  = MATCH_W'(LOCK_COUNT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEEK,
    S_MEASURE,
    S_LOCKED
  } state_t;

  // ---------------------------------------------------------------------------
  // Saturation helpers
  // ---------------------------------------------------------------------------
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic             b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {{CNT_W{1'b0}}, b};
    return sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
  endfunction

  function automatic logic [MATCH_W-1:0] match_inc(input logic [MATCH_W-1:0] m);
    return (m >= LOCK_M) ? LOCK_M : m + MATCH_W'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Front end: synchronizer and edge detect
  // ---------------------------------------------------------------------------
  // These flops ignore i_en. After a re-enable, the edge detector therefore
  // already reflects the current level of the input and cannot see a false
  // rise.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   sync_s;
  logic                   rise;

  always_ff @(posedge i_ref_clk) begin
    if (i_rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_div_clk};
      prev_q <= sync_s;
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];
  assign rise   = sync_s & ~prev_q;

  // ---------------------------------------------------------------------------
  // Measurement state
  // ---------------------------------------------------------------------------
  state_t             state_q,  state_d;
  logic [CNT_W-1:0]   per_q,    per_d;
  logic [CNT_W-1:0]   hi_q,     hi_d;
  logic [MATCH_W-1:0] match_q,  match_d;
  logic               seen_q,   seen_d;
  logic [CNT_W-1:0]   ratio_q,  ratio_d;
  logic [CNT_W-1:0]   high_q,   high_d;
  logic [CNT_W-1:0]   low_q,    low_d;
  logic               valid_q,  valid_d;
  logic               locked_q, locked_d;
  logic               tmo_q,    tmo_d;

  logic               same_period;
  logic [MATCH_W-1:0] match_on_rise;

  // seen_q separates the first report after SEEK from later reports. An
  // o_ratio of 0 left over from a timeout or from idle never counts as a match.
  assign same_period   = seen_q && (per_q == ratio_q);
  assign match_on_rise = same_period ? match_inc(match_q) : MATCH_W'(1);

  always_comb begin
    state_d  = state_q;
    per_d    = per_q;
    hi_d     = hi_q;
    match_d  = match_q;
    seen_d   = seen_q;
    ratio_d  = ratio_q;
    high_d   = high_q;
    low_d    = low_q;
    valid_d  = 1'b0;
    locked_d = locked_q;
    tmo_d    = 1'b0;

    if (!i_en || (state_q == S_IDLE)) begin
      // Idle (or leaving any state on i_en low): discard everything in flight.
      state_d  = i_en ? S_SEEK : S_IDLE;
      per_d    = '0;
      hi_d     = '0;
      match_d  = '0;
      seen_d   = 1'b0;
      ratio_d  = '0;
      high_d   = '0;
      low_d    = '0;
      locked_d = 1'b0;
    end else if (rise) begin
      per_d = CNT_ONE;
      hi_d  = CNT_ONE;
      if (state_q == S_SEEK) begin
        state_d = S_MEASURE;
      end else begin
        ratio_d = per_q;
        high_d  = hi_q;
        low_d   = per_q - hi_q;
        valid_d = 1'b1;
        seen_d  = 1'b1;
        match_d = match_on_rise;
        if (state_q == S_MEASURE) begin
          if (match_on_rise == LOCK_M) begin
            state_d  = S_LOCKED;
            locked_d = 1'b1;
          end
        end else if (!same_period) begin
          // Locked and the period moved. match_on_rise is already 1 here.
          state_d  = S_MEASURE;
          locked_d = 1'b0;
        end
      end
    end else if (per_q == CNT_TMO) begin
      // No edge in time: report loss of clock and start searching again.
      tmo_d    = 1'b1;
      state_d  = S_SEEK;
      per_d    = '0;
      hi_d     = '0;
      match_d  = '0;
      seen_d   = 1'b0;
      ratio_d  = '0;
      high_d   = '0;
      low_d    = '0;
      locked_d = 1'b0;
    end else begin
      per_d = sat_add(per_q, 1'b1);
      hi_d  = sat_add(hi_q, sync_s);
    end
  end

  always_ff @(posedge i_ref_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      per_q    <= '0;
      hi_q     <= '0;
      match_q  <= '0;
      seen_q   <= 1'b0;
      ratio_q  <= '0;
      high_q   <= '0;
      low_q    <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      per_q    <= per_d;
      hi_q     <= hi_d;
      match_q  <= match_d;
      seen_q   <= seen_d;
      ratio_q  <= ratio_d;
      high_q   <= high_d;
      low_q    <= low_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
      tmo_q    <= tmo_d;
    end
  end

  assign o_ratio    = ratio_q;
  assign o_high_cnt = high_q;
  assign o_low_cnt  = low_q;
  assign o_valid    = valid_q;
  assign o_locked   = locked_q;
  assign o_timeout  = tmo_q;

endmodule
